// File: rtl/sonar_varredura_ctrl.sv
// Sonar sweep controller: bounces the servo over N_POS positions and runs a measure/transmit handshake at each one.
// Optional per-half-sweep minimum tracking is enabled with `define SONAR_MIN_TRACK_EN.
module sonar_varredura_ctrl #(
  parameter int N_POS          = 8,
  parameter int POS_W          = 3,
  parameter int DWELL_CYCLES   = 100_000_000,
  parameter int DWELL_W        = 27,
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int TIMEOUT_W      = 22,
  parameter int MED_W          = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ligar,
  input  logic             medida_pronto,
  input  logic [MED_W-1:0] medida,
  input  logic             envio_pronto,
  output logic             medir,
  output logic             transmitir,
  output logic [POS_W-1:0] posicao,
  output logic             direcao,
  output logic             fim_varredura,
  output logic [MED_W-1:0] ultima_medida,
  output logic             erro_medida,
  output logic [MED_W-1:0] min_dist,
  output logic [POS_W-1:0] min_pos,
  output logic [3:0]       db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    ESPERA         = 4'd1,
    MEDIR          = 4'd2,
    AGUARDA_MEDIDA = 4'd3,
    TRANSMITIR     = 4'd4,
    AGUARDA_ENVIO  = 4'd5,
    GIRAR          = 4'd6
  } estado_t;

  localparam logic [DWELL_W-1:0]   DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST   = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [POS_W-1:0]     POS_LAST   = POS_W'(N_POS - 1);
  localparam logic [POS_W-1:0]     POS_PENULT = POS_W'(N_POS - 2);
  localparam logic [MED_W-1:0]     MED_ERRO   = MED_W'('h999);

  estado_t              estado_q, estado_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic                 dir_q, dir_d;
  logic                 medir_q, medir_d;
  logic                 tx_q, tx_d;
  logic                 fim_q, fim_d;
  logic [MED_W-1:0]     ultima_q, ultima_d;
  logic                 erro_q, erro_d;
  logic                 virada;

`ifdef SONAR_MIN_TRACK_EN
  logic [MED_W-1:0] min_dist_q, min_dist_d, trk_dist_q, trk_dist_d;
  logic [POS_W-1:0] min_pos_q, min_pos_d, trk_pos_q, trk_pos_d;
`endif

  // Turnaround happens at either end of the travel, depending on direction.
  assign virada = (dir_q && pos_q == POS_LAST) || (!dir_q && pos_q == '0);

  always_comb begin
    estado_d = estado_q;
    dwell_d  = dwell_q;
    tmo_d    = tmo_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    medir_d  = 1'b0;
    tx_d     = 1'b0;
    fim_d    = 1'b0;
    ultima_d = ultima_q;
    erro_d   = erro_q;
`ifdef SONAR_MIN_TRACK_EN
    min_dist_d = min_dist_q;
    min_pos_d  = min_pos_q;
    trk_dist_d = trk_dist_q;
    trk_pos_d  = trk_pos_q;
`endif
    if (!ligar && estado_q != INICIAL) begin
      estado_d = INICIAL;
    end else begin
      case (estado_q)
        INICIAL: begin
          if (ligar) begin
            estado_d = ESPERA;
            dwell_d  = '0;
          end
        end
        ESPERA: begin
          if (dwell_q == DWELL_LAST) begin
            estado_d = MEDIR;
            medir_d  = 1'b1;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        MEDIR: begin
          tmo_d    = '0;
          estado_d = AGUARDA_MEDIDA;
        end
        AGUARDA_MEDIDA: begin
          // A pronto in the timeout cycle still wins.
          if (medida_pronto) begin
            ultima_d = medida;
            erro_d   = 1'b0;
            tx_d     = 1'b1;
            estado_d = TRANSMITIR;
`ifdef SONAR_MIN_TRACK_EN
            if (medida < trk_dist_q) begin
              trk_dist_d = medida;
              trk_pos_d  = pos_q;
            end
`endif
          end else if (tmo_q == TMO_LAST) begin
            ultima_d = MED_ERRO;
            erro_d   = 1'b1;
            tx_d     = 1'b1;
            estado_d = TRANSMITIR;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        TRANSMITIR: estado_d = AGUARDA_ENVIO;
        AGUARDA_ENVIO: begin
          if (envio_pronto) estado_d = GIRAR;
        end
        GIRAR: begin
          estado_d = ESPERA;
          dwell_d  = '0;
          if (virada) begin
            fim_d = 1'b1;
            dir_d = !dir_q;
            pos_d = dir_q ? POS_PENULT : POS_W'(1);
`ifdef SONAR_MIN_TRACK_EN
            min_dist_d = trk_dist_q;
            min_pos_d  = trk_pos_q;
            trk_dist_d = '1;
            trk_pos_d  = '0;
`endif
          end else begin
            pos_d = dir_q ? pos_q + 1'b1 : pos_q - 1'b1;
          end
        end
        default: estado_d = INICIAL;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= INICIAL;
      dwell_q  <= '0;
      tmo_q    <= '0;
      pos_q    <= '0;
      dir_q    <= 1'b1;
      medir_q  <= 1'b0;
      tx_q     <= 1'b0;
      fim_q    <= 1'b0;
      ultima_q <= '0;
      erro_q   <= 1'b0;
`ifdef SONAR_MIN_TRACK_EN
      min_dist_q <= '1;
      min_pos_q  <= '0;
      trk_dist_q <= '1;
      trk_pos_q  <= '0;
`endif
    end else begin
      estado_q <= estado_d;
      dwell_q  <= dwell_d;
      tmo_q    <= tmo_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      medir_q  <= medir_d;
      tx_q     <= tx_d;
      fim_q    <= fim_d;
      ultima_q <= ultima_d;
      erro_q   <= erro_d;
`ifdef SONAR_MIN_TRACK_EN
      min_dist_q <= min_dist_d;
      min_pos_q  <= min_pos_d;
      trk_dist_q <= trk_dist_d;
      trk_pos_q  <= trk_pos_d;
`endif
    end
  end

  assign medir         = medir_q;
  assign transmitir    = tx_q;
  assign posicao       = pos_q;
  assign direcao       = dir_q;
  assign fim_varredura = fim_q;
  assign ultima_medida = ultima_q;
  assign erro_medida   = erro_q;
  assign db_estado     = estado_q;
`ifdef SONAR_MIN_TRACK_EN
  assign min_dist = min_dist_q;
  assign min_pos  = min_pos_q;
`else
  assign min_dist = '1;
  assign min_pos  = '0;
`endif

endmodule

// File: tb/tb_sonar_varredura_ctrl.sv
// Directed bench for sonar_varredura_ctrl: bounce, timeout, abort, reset and stray handshakes with a latch scoreboard.
module tb_sonar_varredura_ctrl;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset, ligar, medida_pronto, envio_pronto;
  logic [11:0] medida;
  logic        medir, transmitir, direcao, fim_varredura, erro_medida;
  logic [1:0]  posicao, min_pos;
  logic [11:0] ultima_medida, min_dist;
  logic [3:0]  db_estado;

  sonar_varredura_ctrl #(
    .N_POS(N), .POS_W(2), .DWELL_CYCLES(10), .DWELL_W(27),
    .TIMEOUT_CYCLES(20), .TIMEOUT_W(22), .MED_W(12)
  ) dut (
    .clock(clk), .reset(reset), .ligar(ligar), .medida_pronto(medida_pronto),
    .medida(medida), .envio_pronto(envio_pronto), .medir(medir),
    .transmitir(transmitir), .posicao(posicao), .direcao(direcao),
    .fim_varredura(fim_varredura), .ultima_medida(ultima_medida),
    .erro_medida(erro_medida), .min_dist(min_dist), .min_pos(min_pos),
    .db_estado(db_estado)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [11:0] med; logic err; } exp_t;
  exp_t sbq[$];

  int npass = 0, ntotal = 0;
  int nmed = 0, ntx = 0, nfim = 0;
  // reference model
  int          mpos = 0;
  bit          mdir = 1'b1;
  logic [11:0] trk = 12'hFFF, mmin = 12'hFFF;
  int          trk_pos = 0, mmin_pos = 0;
  int          esp_wait = 10;

  always @(negedge clk) begin
    if (medir) nmed++;
    if (transmitir) ntx++;
    if (fim_varredura) nfim++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic wait_pulse(input int which, input int budget, output int n);
    bit seen;
    n = 0; seen = 1'b0;
    while (!seen && n < budget) begin
      tick(); n++;
      seen = (which == 0) ? medir : transmitir;
    end
    chk(which == 0 ? "wait_medir" : "wait_tx", {31'd0, seen}, 32'd1);
  endtask

  task automatic model_latch(input logic [11:0] med);
`ifdef SONAR_MIN_TRACK_EN
    if (med < trk) begin trk = med; trk_pos = mpos; end
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_st"}, db_estado, 0);
    chk({tag, "_pos"}, posicao, 0);
    chk({tag, "_dir"}, direcao, 1);
    chk({tag, "_pulses"}, {medir, transmitir, fim_varredura}, 0);
    chk({tag, "_ultima"}, ultima_medida, 0);
    chk({tag, "_erro"}, erro_medida, 0);
    chk({tag, "_min"}, min_dist, 12'hFFF);
    chk({tag, "_minpos"}, min_pos, 0);
  endtask

  // One full position: dwell, measure (or time out), transmit, rotate.
  task automatic run_pos(input logic [11:0] med, input bit tmo, input bit stray);
    int n; exp_t e; logic [11:0] prev; bit fim_exp;
    wait_pulse(0, 40, n);
    chk("dwell_len", n, esp_wait);
    chk("pos_at_medir", posicao, mpos);
    chk("dir_at_medir", direcao, mdir);
    tick();
    chk("medir_one_cycle", medir, 0);
    chk("st_aguarda_medida", db_estado, 3);
    if (tmo) begin
      sbq.push_back('{12'h999, 1'b1});
      wait_pulse(1, 40, n);
      chk("timeout_latency", n, 20);
    end else begin
      if (stray) begin
        prev = ultima_medida;
        envio_pronto = 1'b1; tick(); envio_pronto = 1'b0;
        chk("stray_envio_st", db_estado, 3);
        chk("stray_envio_ultima", ultima_medida, prev);
      end else tick();
      medida = med; medida_pronto = 1'b1;
      sbq.push_back('{med, 1'b0});
      tick();
      medida_pronto = 1'b0;
      chk("tx_after_pronto", transmitir, 1);
      model_latch(med);
    end
    e = sbq.pop_front();
    chk("ultima_medida", ultima_medida, e.med);
    chk("erro_medida", erro_medida, e.err);
    tick();
    chk("tx_one_cycle", transmitir, 0);
    chk("st_aguarda_envio", db_estado, 5);
    tick();
    envio_pronto = 1'b1; tick(); envio_pronto = 1'b0;
    chk("st_girar", db_estado, 6);
    fim_exp = 1'b0;
    if (mdir && mpos == N - 1)   begin mpos = N - 2; mdir = 1'b0; fim_exp = 1'b1; end
    else if (!mdir && mpos == 0) begin mpos = 1;     mdir = 1'b1; fim_exp = 1'b1; end
    else mpos = mdir ? mpos + 1 : mpos - 1;
`ifdef SONAR_MIN_TRACK_EN
    if (fim_exp) begin mmin = trk; mmin_pos = trk_pos; trk = 12'hFFF; trk_pos = 0; end
`endif
    tick();
    chk("st_espera", db_estado, 1);
    chk("pos_next", posicao, mpos);
    chk("dir_next", direcao, mdir);
    chk("fim_varredura", fim_varredura, fim_exp);
    chk("min_dist", min_dist, mmin);
    chk("min_pos", min_pos, mmin_pos);
    esp_wait = 10;
    if (stray) begin
      prev = ultima_medida;
      medida = 12'h777; medida_pronto = 1'b1; tick(); medida_pronto = 1'b0;
      chk("stray_pronto_st", db_estado, 1);
      chk("stray_pronto_ultima", ultima_medida, prev);
      esp_wait = 9;
    end
  endtask

  initial begin
    int n, cnt0;
    reset = 1'b0; ligar = 1'b0; medida_pronto = 1'b0; envio_pronto = 1'b0; medida = '0;
    tick(); tick();
    chk_reset_vals("reset");

    reset = 1'b1; ligar = 1'b1;
    tick();
    chk("start_espera", db_estado, 1);

    run_pos(12'h150, 1'b0, 1'b0);
    run_pos(12'h080, 1'b0, 1'b0);
    run_pos(12'h200, 1'b0, 1'b0);
    run_pos(12'h095, 1'b0, 1'b0);
`ifdef SONAR_MIN_TRACK_EN
    chk("half_sweep_min", min_dist, 12'h080);
    chk("half_sweep_minpos", min_pos, 1);
`else
    chk("min_disabled", min_dist, 12'hFFF);
`endif
    run_pos(12'h000, 1'b1, 1'b0);
    run_pos(12'h120, 1'b0, 1'b0);
    run_pos(12'h050, 1'b0, 1'b0);
    run_pos(12'h333, 1'b0, 1'b1);
    chk("fim_count", nfim, 2);

    // Abort while waiting for the transmitter.
    wait_pulse(0, 40, n);
    tick(); tick();
    medida = 12'h300; medida_pronto = 1'b1; tick(); medida_pronto = 1'b0;
    chk("abort_tx", transmitir, 1);
    model_latch(12'h300);
    tick();
    chk("abort_pre_st", db_estado, 5);
    ligar = 1'b0; tick();
    chk("abort_st", db_estado, 0);
    chk("abort_pos", posicao, mpos);
    chk("abort_dir", direcao, mdir);
    cnt0 = nmed + ntx + nfim;
    repeat (15) tick();
    chk("abort_no_pulses", nmed + ntx + nfim, cnt0);
    chk("abort_idle_st", db_estado, 0);
    ligar = 1'b1; tick();
    chk("resume_st", db_estado, 1);
    esp_wait = 10;
    run_pos(12'h400, 1'b0, 1'b0);

    // Reset in the middle of a measurement handshake.
    wait_pulse(0, 40, n);
    tick();
    chk("pre_reset_st", db_estado, 3);
    reset = 1'b0; tick();
    chk_reset_vals("midreset");
    reset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule

// File: doc/sonar_varredura_ctrl.md
Name: sonar_varredura_ctrl

Overview:
- Parametrised sweep controller for the sonar subsystem.
- Steps the servo position with an up/down bounce over N_POS positions and dwells at each position.
- At each position it requests one distance measurement from the HC-SR04 interface, then requests one ASCII transmission, using pulse/pronto handshakes.
- Adds measurement timeout, direction output, end-of-sweep flag and per-half-sweep minimum-distance capture, which the previous datapath lacked.
- Sits between the top-level control unit and the interface_hcsr04, servo and transmissor_ascii instances.

Parameters:
- N_POS, 8, number of servo positions (must be >= 2).
- POS_W, 3, width of posicao (must satisfy 2^POS_W >= N_POS).
- DWELL_CYCLES, 100_000_000, dwell length per position in clock cycles (2 s at 50 MHz).
- DWELL_W, 27, dwell counter width.
- TIMEOUT_CYCLES, 2_500_000, maximum wait for medida_pronto (50 ms).
- TIMEOUT_W, 22, timeout counter width.
- MED_W, 12, distance width (3 BCD digits).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; 0 = reset.
- ligar  in  1  scan enable, level-sensitive.
- medida_pronto  in  1  one-cycle pulse from the sensor interface.
- medida  in  MED_W  BCD distance; valid when medida_pronto=1.
- envio_pronto  in  1  one-cycle pulse from the transmitter.
- medir  out  1  one-cycle measurement request.
- transmitir  out  1  one-cycle transmit request.
- posicao  out  POS_W  current servo position index.
- direcao  out  1  sweep direction; 1 = increasing.
- fim_varredura  out  1  one-cycle pulse at each turnaround.
- ultima_medida  out  MED_W  last latched distance.
- erro_medida  out  1  last measurement timed out.
- min_dist  out  MED_W  minimum distance of the last completed half sweep.
- min_pos  out  POS_W  position at which min_dist was taken.
- db_estado  out  4  state code.

Behaviour:
- Reset (reset=0 at a rising edge), from any state:
  - state INICIAL; posicao=0; direcao=1.
  - medir, transmitir, fim_varredura = 0.
  - ultima_medida=0; erro_medida=0.
  - min_dist=12'hFFF; min_pos=0; internal tracker = 12'hFFF/0.
  - All counters cleared. A reset mid-handshake aborts the handshake without glitching any pulse.
- All outputs are registered. medir, transmitir and fim_varredura are high only in the cycle after the transition that raises them.
- States and db_estado codes: INICIAL=0, ESPERA=1, MEDIR=2, AGUARDA_MEDIDA=3, TRANSMITIR=4, AGUARDA_ENVIO=5, GIRAR=6.
- INICIAL: ligar=1 -> ESPERA, dwell counter cleared.
- ESPERA: occupies exactly DWELL_CYCLES cycles, then -> MEDIR.
- MEDIR: medir=1 for one cycle; timeout counter cleared; -> AGUARDA_MEDIDA.
- AGUARDA_MEDIDA, on medida_pronto=1:
  - ultima_medida <= medida; erro_medida <= 0; -> TRANSMITIR.
- AGUARDA_MEDIDA, on timeout (counter reaches TIMEOUT_CYCLES-1 with no pronto):
  - ultima_medida <= 12'h999; erro_medida <= 1; -> TRANSMITIR.
- TRANSMITIR: transmitir=1 for one cycle; -> AGUARDA_ENVIO. No timeout is applied to envio_pronto.
- AGUARDA_ENVIO: envio_pronto=1 -> GIRAR.
- GIRAR: one cycle, then -> ESPERA.
  - direcao=1 and posicao=N_POS-1: posicao <= N_POS-2; direcao <= 0; fim_varredura=1.
  - direcao=0 and posicao=0: posicao <= 1; direcao <= 1; fim_varredura=1.
  - Otherwise posicao increments or decrements by 1.
- ligar=0 in any state except INICIAL -> INICIAL at the next edge.
  - posicao, direcao and the min tracker are retained.
  - Any pending pulse is not issued.
  - Restarting continues from the held position.
- medida_pronto outside AGUARDA_MEDIDA and envio_pronto outside AGUARDA_ENVIO are ignored.
- A medida_pronto arriving in the same cycle the timeout fires takes priority over the timeout.
- Measurement comparisons are unsigned on the full MED_W vector; BCD ordering is preserved.

Optional Feature:
- Macro: SONAR_MIN_TRACK_EN.
- Defined:
  - On each valid latch (not a timeout), if medida < tracker the tracker <= {medida, posicao}.
  - In GIRAR at a turnaround: min_dist/min_pos <= tracker, then tracker <= 12'hFFF/0.
  - A turnaround measurement therefore counts for the ending half sweep.
- Not defined: min_dist is constant 12'hFFF, min_pos is constant 0, and no tracker logic is synthesised.

Test Plan:
All scenarios use N_POS=4, DWELL_CYCLES=10, TIMEOUT_CYCLES=20, and respond to medir/transmitir with pronto after 3 cycles unless stated otherwise.
- Step timing: reset released, ligar=1 -> db_estado=1 next cycle; medir pulses once, exactly 10 cycles after ESPERA is entered; transmitir pulses 1 cycle after medida_pronto is sampled.
- Bounce: run 8 positions -> posicao 0,1,2,3,2,1,0,1; direcao falls leaving 3 and rises leaving 0; fim_varredura pulses exactly twice.
- Timeout: withhold medida_pronto -> 20 cycles after medir, ultima_medida=12'h999 and erro_medida=1; transmitir pulses; next valid measurement clears erro_medida.
- Min tracking (macro defined): measurements 12'h150, 12'h080, 12'h200, 12'h095 at positions 0..3 -> at the turnaround min_dist=12'h080, min_pos=1. Macro undefined -> min_dist stays 12'hFFF.
- Abort and reset: drop ligar in AGUARDA_ENVIO -> INICIAL, posicao held, no further pulses; raise ligar -> resumes at the same posicao. reset=0 in AGUARDA_MEDIDA -> all outputs at their reset values on the next cycle.
- Stray handshakes: pulse medida_pronto during ESPERA and envio_pronto during AGUARDA_MEDIDA -> no state change and ultima_medida unchanged.
